// File: rtl/ps2_host_tx_if.sv
// Command-side port bundle of the PS/2 host transmitter: request in, status out.
// tx_start is a one-cycle request that is taken only while busy is 0; tx_data is
// captured on that cycle, and done pulses once per taken request with ack_ok/timeout valid.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       timeout;
  logic [2:0] dbg_state;

  modport master (
    output tx_data,
    output tx_start,
    input  busy,
    input  done,
    input  ack_ok,
    input  timeout,
    input  dbg_state
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output busy,
    output done,
    output ack_ok,
    output timeout,
    output dbg_state
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: request-to-send, 11-bit frame shifted on
// device clock falling edges, ack capture, and start/packet timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int START_TIMEOUT  = 375000,
  parameter int PACKET_TIMEOUT = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic          clk25,
  input  logic          rst,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_P = (MAX_A > PACKET_TIMEOUT) ? MAX_A : PACKET_TIMEOUT;
  localparam int CW    = $clog2(MAX_P) + 1;
  localparam int FW    = $clog2(FILTER_LEN) + 1;

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_DAT    = CW'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] PKT_LAST   = CW'(PACKET_TIMEOUT - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;

  // Index 0 is the clock pin, index 1 the data pin.
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    filt_q, filt_d;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];
  logic          clk_fall;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [9:0]    frame_q, frame_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          timeout_q, timeout_d;
  logic          to_entry_q, to_entry_d;

  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] pkt_inc;
  logic          pkt_expired;

  // A new level is accepted only after FILTER_LEN consecutive samples disagree with the old one.
  always_comb begin
    sync1_d = {ps2_dat_in, ps2_clk_in};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] >= FILT_LAST) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign clk_fall = filt_q[0] & ~filt_d[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    bit_idx_d   = bit_idx_q;
    frame_d     = frame_q;
    clk_oe_d    = clk_oe_q;
    dat_oe_d    = dat_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_ok_d    = ack_ok_q;
    timeout_d   = timeout_q;
    to_entry_d  = to_entry_q;
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    pkt_inc     = (pkt_cnt_q == CNT_MAX) ? pkt_cnt_q : pkt_cnt_q + 1'b1;
    pkt_expired = (pkt_cnt_q >= PKT_LAST);

    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        if (host.tx_start) begin
          // Frame bits after the start bit: data LSB first, odd parity, stop.
          frame_d   = {1'b1, ~^host.tx_data, host.tx_data};
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          cnt_d     = '0;
          ack_ok_d  = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        cnt_d = cnt_inc;
        // Start bit goes low one cycle before the clock is let go.
        if (cnt_q >= INH_DAT) dat_oe_d = 1'b1;
        if (cnt_q >= INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        cnt_d = cnt_inc;
        if (clk_fall) begin
          dat_oe_d  = ~frame_q[0];
          bit_idx_d = 4'd1;
          pkt_cnt_d = '0;
          state_d   = ST_SHIFT;
        end else if (cnt_q >= START_LAST) begin
          clk_oe_d   = 1'b0;
          dat_oe_d   = 1'b0;
          timeout_d  = 1'b1;
          ack_ok_d   = 1'b0;
          to_entry_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RECOVER;
        end
      end

      ST_SHIFT: begin
        pkt_cnt_d = pkt_inc;
        if (pkt_expired) begin
          clk_oe_d   = 1'b0;
          dat_oe_d   = 1'b0;
          timeout_d  = 1'b1;
          ack_ok_d   = 1'b0;
          to_entry_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RECOVER;
        end else if (clk_fall) begin
          dat_oe_d = ~frame_q[bit_idx_q];
          if (bit_idx_q == 4'd9) begin
            state_d = ST_ACK;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end

      ST_ACK: begin
        pkt_cnt_d = pkt_inc;
        dat_oe_d  = 1'b0;
        if (pkt_expired) begin
          clk_oe_d   = 1'b0;
          timeout_d  = 1'b1;
          ack_ok_d   = 1'b0;
          to_entry_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RECOVER;
        end else if (clk_fall) begin
          ack_ok_d   = ~filt_q[1];
          timeout_d  = 1'b0;
          to_entry_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_RECOVER;
        end
      end

      ST_RECOVER: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        cnt_d    = cnt_inc;
        if (to_entry_q || (filt_q == 2'b11)) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          to_entry_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (cnt_q >= PKT_LAST) begin
          // Bus never went idle after the frame.
          done_d    = 1'b1;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          ack_ok_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pkt_cnt_q  <= '0;
      bit_idx_q  <= '0;
      frame_q    <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      timeout_q  <= 1'b0;
      to_entry_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      fcnt_q[0]  <= fcnt_d[0];
      fcnt_q[1]  <= fcnt_d[1];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      bit_idx_q  <= bit_idx_d;
      frame_q    <= frame_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      timeout_q  <= timeout_d;
      to_entry_q <= to_entry_d;
    end
  end

  assign ps2_clk_oe     = clk_oe_q;
  assign ps2_dat_oe     = dat_oe_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.ack_ok    = ack_ok_q;
  assign host.timeout   = timeout_q;
  assign host.dbg_state = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device that clocks
// the frame in, records the bits it samples, and optionally acks.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int STO  = 400;
  localparam int PTO  = 2000;
  localparam int FL   = 8;
  localparam int HALF = 40;

  typedef struct {
    logic [7:0] data;
    bit         do_ack;
    logic       par;
    logic       exp_ack;
  } vec_t;

  logic clk25 = 1'b0;
  logic rst;
  logic ps2_clk_oe, ps2_dat_oe;
  logic dev_clk_rel, dev_dat_rel, glitch;
  logic ps2_clk_line, ps2_dat_line;

  always #20 clk25 = ~clk25;

  ps2_host_tx_if host_if ();

  assign ps2_clk_line = dev_clk_rel & ~ps2_clk_oe & ~glitch;
  assign ps2_dat_line = dev_dat_rel & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .PACKET_TIMEOUT (PTO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk25      (clk25),
    .rst        (rst),
    .host       (host_if),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_ack, done_to, done_clk_oe, done_dat_oe;

  logic [10:0] exp_q [$];
  logic [1:0]  sts_q [$];

  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25) begin
    if (host_if.done) begin
      done_cnt    <= done_cnt + 1;
      done_cyc    <= cyc;
      done_ack    <= host_if.ack_ok;
      done_to     <= host_if.timeout;
      done_clk_oe <= ps2_clk_oe;
      done_dat_oe <= ps2_dat_oe;
    end
  end

  initial begin
    #3_600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk25);
    host_if.tx_data  = d;
    host_if.tx_start = 1'b1;
    acc_cyc          = cyc + 1;
    @(negedge clk25);
    host_if.tx_start = 1'b0;
  endtask

  task automatic wait_release(output int nlow, output bit ok);
    nlow = 0;
    ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ps2_clk_oe) nlow++;
      if (!ps2_clk_oe && ps2_dat_oe && host_if.busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk25);
    end
  endtask

  task automatic wait_done(input int prev, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk25);
      if (done_cnt != prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // mode 0: plain frame; 1: reset pulse while data bit 4 is on the wire;
  // 2: stray tx_start plus a short clock glitch mid-frame.
  task automatic device_frame(input bit do_ack, input int mode, output logic [10:0] bits);
    bits    = '0;
    bits[0] = ps2_dat_line;
    for (int b = 1; b <= 10; b++) begin
      if (mode == 2 && b == 6) begin
        repeat (HALF / 2) @(negedge clk25);
        glitch = 1'b1;
        repeat (3) @(negedge clk25);
        glitch = 1'b0;
        repeat (HALF / 2 - 3) @(negedge clk25);
      end else begin
        repeat (HALF) @(negedge clk25);
      end
      dev_clk_rel = 1'b0;
      if (mode == 1 && b == 5) begin
        repeat (20) @(negedge clk25);
        rst = 1'b1;
        @(negedge clk25);
        rst = 1'b0;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        check("rst_busy", host_if.busy, 0);
        dev_clk_rel = 1'b1;
        return;
      end
      if (mode == 2 && b == 3) begin
        host_if.tx_data  = 8'h55;
        host_if.tx_start = 1'b1;
        @(negedge clk25);
        host_if.tx_start = 1'b0;
        repeat (HALF - 1) @(negedge clk25);
      end else begin
        repeat (HALF) @(negedge clk25);
      end
      dev_clk_rel = 1'b1;
      bits[b]     = ps2_dat_line;
    end
    repeat (HALF / 2) @(negedge clk25);
    if (do_ack) dev_dat_rel = 1'b0;
    repeat (HALF / 2) @(negedge clk25);
    dev_clk_rel = 1'b0;
    repeat (HALF) @(negedge clk25);
    dev_clk_rel = 1'b1;
    repeat (HALF / 2) @(negedge clk25);
    dev_dat_rel = 1'b1;
  endtask

  task automatic run_tx(input logic [7:0] d, input bit do_ack, input int mode,
                        input logic par, input logic exp_ack, input string tag);
    int          nlow;
    int          prev;
    bit          ok;
    logic [10:0] fr;
    logic [10:0] ef;
    logic [1:0]  es;
    prev = done_cnt;
    if (mode != 1) begin
      exp_q.push_back(frame_of(d));
      sts_q.push_back({exp_ack, 1'b0});
    end
    start_tx(d);
    check({tag, "_busy_rise"}, host_if.busy, 1);
    wait_release(nlow, ok);
    check({tag, "_release_seen"}, ok, 1);
    check({tag, "_clk_low_cycles"}, nlow, INH);
    if (!ok) return;
    device_frame(do_ack, mode, fr);
    if (mode == 1) begin
      repeat (150) @(negedge clk25);
      check({tag, "_no_done"}, done_cnt, prev);
      check({tag, "_idle_after_rst"}, host_if.dbg_state, 0);
      return;
    end
    wait_done(prev, 300, ok);
    check({tag, "_done_seen"}, ok, 1);
    if (!ok) return;
    ef = exp_q.pop_front();
    es = sts_q.pop_front();
    check({tag, "_frame"}, fr, ef);
    check({tag, "_parity_bit"}, fr[9], par);
    check({tag, "_ack_ok"}, done_ack, es[1]);
    check({tag, "_timeout"}, done_to, es[0]);
    repeat (200) @(negedge clk25);
    check({tag, "_single_done"}, done_cnt, prev + 1);
    check({tag, "_busy_clear"}, host_if.busy, 0);
  endtask

  initial begin
    vec_t vecs [5];
    int   prev;
    int   diff;
    bit   ok;
    logic [1:0] es;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'hA5, 1'b0, 1'b1, 1'b0};

    rst              = 1'b1;
    glitch           = 1'b0;
    dev_clk_rel      = 1'b1;
    dev_dat_rel      = 1'b1;
    host_if.tx_data  = 8'h00;
    host_if.tx_start = 1'b0;
    repeat (4) @(negedge clk25);
    host_if.tx_start = 1'b1;
    @(negedge clk25);
    check("rst_wins_busy", host_if.busy, 0);
    check("rst_wins_clk_oe", ps2_clk_oe, 0);
    host_if.tx_start = 1'b0;
    rst              = 1'b0;
    @(negedge clk25);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_dat_oe", ps2_dat_oe, 0);
    check("reset_busy", host_if.busy, 0);
    check("reset_done", host_if.done, 0);
    check("reset_ack_ok", host_if.ack_ok, 0);
    check("reset_timeout", host_if.timeout, 0);
    check("reset_state", host_if.dbg_state, 0);
    repeat (20) @(negedge clk25);

    for (int i = 0; i < 5; i++) begin
      run_tx(vecs[i].data, vecs[i].do_ack, 0, vecs[i].par, vecs[i].exp_ack,
             $sformatf("vec%0d", i));
    end

    // Device never clocks: start timeout.
    prev = done_cnt;
    sts_q.push_back(2'b01);
    start_tx(8'hED);
    wait_done(prev, 1000, ok);
    check("start_to_done_seen", ok, 1);
    if (ok) begin
      es   = sts_q.pop_front();
      diff = done_cyc - acc_cyc;
      n_tests++;
      if (diff < INH + STO || diff > INH + STO + 2) begin
        n_fail++;
        $display("FAIL start_to_latency: got %0d cycles expected %0d +/-1", diff, INH + STO + 1);
      end
      check("start_to_ack_ok", done_ack, es[1]);
      check("start_to_timeout", done_to, es[0]);
      check("start_to_clk_oe", done_clk_oe, 0);
      check("start_to_dat_oe", done_dat_oe, 0);
    end
    repeat (50) @(negedge clk25);

    run_tx(8'hED, 1'b1, 1, 1'b1, 1'b0, "rst_mid");
    run_tx(8'hFF, 1'b1, 0, 1'b1, 1'b1, "after_rst");
    run_tx(8'hED, 1'b1, 2, 1'b1, 1'b1, "stray_start_glitch");

    check("exp_q_drained", exp_q.size(), 0);
    check("sts_q_drained", sts_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
